// File: rtl/imem_loader.sv
// Instruction memory loader: a writer streams program words in LOAD mode, and
// the processor then fetches them by PC in RUN mode with one cycle of latency.
//
// state | meaning
// IDLE  | no activity; waits for a load request or a loaded program to run
// LOAD  | ready to accept one word from the writer
// ACK   | word taken (or refused when full); waits for Load_Valid to drop
// RUN   | program loaded, fetches by PC are served
module imem_loader #(
  parameter int DEPTH = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load_Mode,
  input  logic       Load_Valid,
  input  logic [7:0] Load_Data,
  input  logic [7:0] PC,
  output logic       Load_Ready,
  output logic [7:0] Instruction,
  output logic       Run_Enable,
  output logic [7:0] Load_Count,
  output logic       Overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, ACK, RUN} state_t;

  state_t     state;
  logic [8:0] cnt;
  logic [7:0] mem [2**AW];
  logic       full;
  logic       pc_hit;
  logic       mem_we;

  // The count needs 9 bits to hold DEPTH=256; the 8-bit port clamps at 255.
  assign full       = (cnt >= DEPTH_CNT);
  assign pc_hit     = ({1'b0, PC} < cnt);
  assign Load_Count = cnt[8] ? 8'hFF : cnt[7:0];
  assign Load_Ready = (state == LOAD);
  assign Run_Enable = (state == RUN);

  always_comb begin
    mem_we = 1'b0;
    if (!Reset && state == LOAD && Load_Mode && Load_Valid && !full)
      mem_we = 1'b1;
  end

  // Storage is never reset; words at or beyond the count are masked on read.
  always_ff @(posedge Clk) begin
    if (mem_we)
      mem[cnt[AW-1:0]] <= Load_Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 9'd0;
      Overflow    <= 1'b0;
      Instruction <= 8'h00;
    end else begin
      Instruction <= 8'h00;
      case (state)
        IDLE: begin
          if (Load_Mode) begin
            state    <= LOAD;
            cnt      <= 9'd0;
            Overflow <= 1'b0;
          end else if (cnt != 9'd0) begin
            state <= RUN;
          end
        end
        LOAD: begin
          // Dropping Load_Mode wins over a word offered in the same cycle.
          if (!Load_Mode) begin
            state <= IDLE;
          end else if (Load_Valid) begin
            if (full)
              Overflow <= 1'b1;
            else
              cnt <= cnt + 9'd1;
            state <= ACK;
          end
        end
        ACK: begin
          if (!Load_Valid)
            state <= Load_Mode ? LOAD : IDLE;
        end
        RUN: begin
          if (Load_Mode) begin
            state    <= LOAD;
            cnt      <= 9'd0;
            Overflow <= 1'b0;
          end else if (pc_hit) begin
            Instruction <= mem[PC[AW-1:0]];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (DEPTH=4): status checks against a small
// model plus a fetch scoreboard for the one-cycle instruction latency.
module tb_imem_loader;

  localparam int DEPTH = 4;

  logic       Clk;
  logic       Reset;
  logic       Load_Mode;
  logic       Load_Valid;
  logic [7:0] Load_Data;
  logic [7:0] PC;
  logic       Load_Ready;
  logic [7:0] Instruction;
  logic       Run_Enable;
  logic [7:0] Load_Count;
  logic       Overflow;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Load_Mode   (Load_Mode),
    .Load_Valid  (Load_Valid),
    .Load_Data   (Load_Data),
    .PC          (PC),
    .Load_Ready  (Load_Ready),
    .Instruction (Instruction),
    .Run_Enable  (Run_Enable),
    .Load_Count  (Load_Count),
    .Overflow    (Overflow)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_mem [DEPTH];
  int         model_cnt = 0;
  logic       model_ovf = 1'b0;
  logic [7:0] exp_q [$];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] data, input int hold);
    Load_Data  = data;
    Load_Valid = 1'b1;
    if (model_cnt < DEPTH) begin
      model_mem[model_cnt] = data;
      model_cnt++;
    end else begin
      model_ovf = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("ready_low_in_ack", Load_Ready, 1'b0);
      check("count_during_hold", Load_Count, model_cnt);
    end
    Load_Valid = 1'b0;
    tick();
    check("ready_after_release", Load_Ready, 1'b1);
    check("count_after_word", Load_Count, model_cnt);
    check("overflow_after_word", Overflow, model_ovf);
  endtask

  task automatic fetch(input logic [7:0] pc);
    PC = pc;
    exp_q.push_back((int'(pc) < model_cnt) ? model_mem[pc[1:0]] : 8'h00);
    tick();
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      check("fetch_instr", Instruction, exp_q.pop_front());
      check("fetch_run_en", Run_Enable, 1'b1);
    end
  endtask

  task automatic start_run();
    Load_Mode = 1'b0;
    tick();
    tick();
    check("run_enable_on", Run_Enable, 1'b1);
    check("ready_off_in_run", Load_Ready, 1'b0);
  endtask

  task automatic enter_load();
    Load_Mode = 1'b1;
    tick();
    model_cnt = 0;
    model_ovf = 1'b0;
    check("enter_load_ready", Load_Ready, 1'b1);
    check("enter_load_count", Load_Count, 0);
    check("enter_load_instr", Instruction, 8'h00);
    check("enter_load_run_en", Run_Enable, 1'b0);
  endtask

  initial begin
    Reset      = 1'b1;
    Load_Mode  = 1'b0;
    Load_Valid = 1'b0;
    Load_Data  = 8'h00;
    PC         = 8'h00;
    tick();
    tick();
    check("rst_ready", Load_Ready, 1'b0);
    check("rst_run_en", Run_Enable, 1'b0);
    check("rst_instr", Instruction, 8'h00);
    check("rst_count", Load_Count, 0);
    check("rst_ovf", Overflow, 1'b0);
    Reset = 1'b0;
    tick();
    check("idle_holds", Run_Enable, 1'b0);

    // Three words, each held for three cycles.
    enter_load();
    push_word(8'h21, 3);
    push_word(8'h42, 3);
    push_word(8'h63, 3);
    start_run();
    for (int p = 0; p < 5; p++) fetch(8'(p));
    for (int k = 0; k < 6; k++) fetch(8'($urandom_range(0, 7)));

    // A long Load_Valid stores a single word.
    enter_load();
    push_word(8'hA5, 10);

    // Fill to DEPTH, then two refused writes.
    push_word(8'hB1, 2);
    push_word(8'hB2, 1);
    push_word(8'hB3, 1);
    push_word(8'hB4, 2);
    push_word(8'hB5, 1);
    check("ovf_count_sat", Load_Count, DEPTH);
    check("ovf_sticky", Overflow, 1'b1);
    start_run();
    for (int p = 0; p < 6; p++) fetch(8'(p));

    // A shorter reload hides the older words beyond the new count.
    enter_load();
    check("ovf_cleared", Overflow, 1'b0);
    push_word(8'hC7, 1);
    start_run();
    for (int p = 0; p < 4; p++) fetch(8'(p));

    // Leaving LOAD discards a word offered in the same cycle.
    enter_load();
    push_word(8'hD1, 1);
    Load_Mode  = 1'b0;
    Load_Valid = 1'b1;
    Load_Data  = 8'hEE;
    tick();
    check("abort_ready", Load_Ready, 1'b0);
    check("abort_run_en", Run_Enable, 1'b0);
    check("abort_count", Load_Count, 1);
    Load_Valid = 1'b0;
    tick();
    check("abort_then_run", Run_Enable, 1'b1);
    fetch(8'h00);
    fetch(8'h01);

    // Reset in the middle of RUN.
    PC = 8'h01;
    tick();
    Reset = 1'b1;
    tick();
    check("rst_run_instr", Instruction, 8'h00);
    check("rst_run_en", Run_Enable, 1'b0);
    check("rst_run_count", Load_Count, 0);
    Reset = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", Run_Enable, 1'b0);
      check("post_rst_instr", Instruction, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of 8-bit instruction words stored; legal range 1..256.
REQ-002 The block SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 The block SHALL have port Load_Mode  input  1  1 = request program-load mode, 0 = request run mode.
REQ-005 The block SHALL have port Load_Valid  input  1  writer presents a word on Load_Data; held high until released.
REQ-006 The block SHALL have port Load_Data  input  8  instruction word to store.
REQ-007 The block SHALL have port PC  input  8  fetch address from the processor.
REQ-008 The block SHALL have port Load_Ready  output  1  block accepts a word this cycle.
REQ-009 The block SHALL have port Instruction  output  8  registered instruction word returned to the processor.
REQ-010 The block SHALL have port Run_Enable  output  1  a program is loaded and fetches are being served.
REQ-011 The block SHALL have port Load_Count  output  8  number of words stored in the current program.
REQ-012 The block SHALL have port Overflow  output  1  sticky: a write was attempted with the memory full.

Function
REQ-013 The block SHALL implement the states IDLE, LOAD, ACK and RUN, with the state register clocked by Clk.
REQ-014 IDLE SHALL go to LOAD when Load_Mode=1, clearing Load_Count and Overflow on that edge.
REQ-015 IDLE SHALL go to RUN when Load_Mode=0 and Load_Count>0; otherwise IDLE SHALL hold.
REQ-016 In LOAD, Load_Ready SHALL be 1 (combinational decode of state) and all other states SHALL drive Load_Ready=0.
REQ-017 In LOAD, Load_Mode=0 SHALL return the state to IDLE; this has priority over Load_Valid, and a word presented in that cycle SHALL be discarded.
REQ-018 In LOAD, Load_Valid=1 with Load_Count<DEPTH SHALL write mem[Load_Count]=Load_Data, increment Load_Count and go to ACK, all on the same edge.
REQ-019 In LOAD, Load_Valid=1 with Load_Count=DEPTH SHALL perform no write, leave Load_Count unchanged, set Overflow=1 and go to ACK.
REQ-020 ACK SHALL hold until Load_Valid=0, so that one held Load_Valid pulse stores exactly one word.
REQ-021 When Load_Valid=0 in ACK, the state SHALL go to LOAD if Load_Mode=1, else to IDLE.
REQ-022 In RUN, Run_Enable SHALL be 1; in every other state Run_Enable SHALL be 0.
REQ-023 In RUN, each edge SHALL load Instruction with mem[PC] if PC<Load_Count, else 8'h00, giving one-cycle fetch latency.
REQ-024 Outside RUN, Instruction SHALL be loaded with 8'h00 on each edge.
REQ-025 In RUN, Load_Mode=1 SHALL go to LOAD, clearing Load_Count and Overflow; Instruction SHALL be 8'h00 from the next edge.
REQ-026 Memory contents SHALL not be cleared by a new load; words at or beyond Load_Count SHALL be unreadable, returning 8'h00.
REQ-027 Load_Count SHALL saturate at DEPTH and never wrap.

Reset
REQ-028 Reset=1 SHALL force state=IDLE, Instruction=8'h00, Load_Count=0, Overflow=0, Load_Ready=0 and Run_Enable=0 on the next edge, overriding any in-progress load or fetch.
REQ-029 Memory array contents need not be cleared by Reset; they are unreadable because Load_Count=0.

Verification
REQ-030 Load three words: Load_Mode=1, then pulse Load_Valid with 8'h21, 8'h42, 8'h63, each held 3 cycles -> Load_Count=3, Overflow=0, exactly 3 writes.
REQ-031 After REQ-030, set Load_Mode=0 and drive PC=0,1,2,3 -> Run_Enable=1; Instruction=21,42,63,00 each one cycle after its PC.
REQ-032 With DEPTH=4, present 5 words -> Load_Count=4, Overflow=1, mem[3] unchanged by the 5th word.
REQ-033 Load_Valid held high for 10 cycles in LOAD -> a single write, with Load_Ready=0 after the first edge until Load_Valid falls.
REQ-034 Assert Reset during RUN with PC=1 -> next edge gives Instruction=00, Run_Enable=0, Load_Count=0; with Load_Mode=0 the block stays in IDLE.
REQ-035 Load_Mode=0 and Load_Valid=1 in the same LOAD cycle -> no write, state=IDLE, Load_Count unchanged.
